rom_arbiter: RTL

Two-port, round-robin arbiter and access sequencer for the shared program/constant ROM. Instruction fetch (port 0) and data load (port 1) each post a request with an address. The arbiter grants one port at a time and drives the ROM's `address`/`ce` for exactly one cycle. It registers the ROM's combinational output and returns it with a one-cycle acknowledge. It sits between the processor core and the ROM instance, and is the only block that drives the ROM's `ce`.

---
 rtl/rom_arbiter_pkg.sv | 13 +
 rtl/rom_arbiter_rr_pick2.sv | 21 ++
 rtl/rom_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM arbiter: FSM state encoding and port IDs.
package rom_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

endpackage

// File: rtl/rom_arbiter_rr_pick2.sv
// Two-way round-robin picker. A set mask bit removes that requester from
// consideration; on a tie the port that did not win last time is chosen.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic [1:0] mask,
  output logic       valid,
  output logic       winner
);

  logic eff0;
  logic eff1;

  assign eff0   = req0 & ~mask[0];
  assign eff1   = req1 & ~mask[1];
  assign valid  = eff0 | eff1;
  // Tie goes to !last; otherwise whichever single request is present.
  assign winner = (eff0 && eff1) ? ~last : eff1;

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter and access sequencer for the shared program/constant
// ROM. Port 0 is instruction fetch, port 1 is data load. Each transaction is
// one ROM read cycle (ACCESS) followed by one acknowledge cycle (RESP).
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              grant,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ce,
  input  logic [DATA_W-1:0] rom_data
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;

  logic [1:0]          pick_mask;
  logic                pick_valid;
  logic                pick_winner;

  // During RESP the current owner is hidden so only the other port can win.
  assign pick_mask = (state_q == ST_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .mask   (pick_mask),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // State and datapath registers; everything returns to reset values at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      grant_q <= PORT_FETCH;
      last_q  <= PORT_LOAD;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others, independent of statement order.
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: start, sequence and chain transactions.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ACCESS;
          grant_d = pick_winner;
          addr_d  = pick_winner ? addr1 : addr0;
        end
      end
      ST_ACCESS: begin
        rdata_d = rom_data;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        last_d = grant_q;
        if (pick_valid) begin
          state_d = ST_ACCESS;
          grant_d = pick_winner;
          addr_d  = pick_winner ? addr1 : addr0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack0     = (state_q == ST_RESP) && (grant_q == PORT_FETCH);
  assign ack1     = (state_q == ST_RESP) && (grant_q == PORT_LOAD);
  assign busy     = (state_q == ST_ACCESS) || (state_q == ST_RESP);
  assign rom_ce   = (state_q == ST_ACCESS);
  assign rom_addr = addr_q;
  assign rdata    = rdata_q;
  assign grant    = grant_q;

endmodule
